// File: rtl/approx_add8_msb_pipe.sv
// rtl/approx_add8_msb_pipe.sv - upper-part exact adder stage of the 8-bit approximate adder, 2-stage valid/ready pipe
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid, in_ready  upstream handshake (in_ready is combinational)
//   a_msb, b_msb        operand upper bits [7:2]
//   s_lsb               approximate LSB sum from the LSB stage (passed through)
//   cin1                carry from the LSB stage into the upper part
//   out_valid, out_ready downstream handshake
//   sum, cout           {upper exact sum, s_lsb} and upper carry-out
//
// Build option APPROX_ADD_SAT_EN: when defined, an upper carry saturates
// sum to all ones (cout stays 1); otherwise sum wraps and cout reports it.

module approx_add8_msb_pipe #(
  parameter int MSB_W = 6,
  parameter int LSB_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [MSB_W-1:0]       a_msb,
  input  logic [MSB_W-1:0]       b_msb,
  input  logic [LSB_W-1:0]       s_lsb,
  input  logic                   cin1,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [MSB_W+LSB_W-1:0] sum,
  output logic                   cout
);

  // Stage 1 holding registers
  logic                   s1_valid_q, s1_valid_d;
  logic [MSB_W-1:0]       s1_a_q, s1_a_d;
  logic [MSB_W-1:0]       s1_b_q, s1_b_d;
  logic [LSB_W-1:0]       s1_s_q, s1_s_d;
  logic                   s1_c_q, s1_c_d;

  // Stage 2 (output) registers
  logic                   out_valid_q, out_valid_d;
  logic [MSB_W+LSB_W-1:0] sum_q, sum_d;
  logic                   cout_q, cout_d;

  logic                   s2_adv;
  logic                   s1_adv;
  logic                   in_fire;
  logic [MSB_W:0]         add_full;

  always_comb begin
    s2_adv   = ~out_valid_q | out_ready;
    s1_adv   = s1_valid_q & s2_adv;
    in_ready = ~s1_valid_q | s2_adv;
    in_fire  = in_valid & in_ready;

    // Full-width add so the carry is taken before any truncation.
    add_full = {1'b0, s1_a_q} + {1'b0, s1_b_q} + {{MSB_W{1'b0}}, s1_c_q};

    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_s_d      = s1_s_q;
    s1_c_d      = s1_c_q;
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;

    // S1 reloads on a transfer in; otherwise it empties when its word moves on.
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_a_d     = a_msb;
      s1_b_d     = b_msb;
      s1_s_d     = s_lsb;
      s1_c_d     = cin1;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    // S2 only changes when it is empty or being drained.
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
`ifdef APPROX_ADD_SAT_EN
        if (add_full[MSB_W]) begin
          sum_d  = '1;
          cout_d = 1'b1;
        end else begin
          sum_d  = {add_full[MSB_W-1:0], s1_s_q};
          cout_d = 1'b0;
        end
`else
        sum_d  = {add_full[MSB_W-1:0], s1_s_q};
        cout_d = add_full[MSB_W];
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_s_q      <= '0;
      s1_c_q      <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_s_q      <= s1_s_d;
      s1_c_q      <= s1_c_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_approx_add8_msb_pipe.sv
// tb/tb_approx_add8_msb_pipe.sv - scoreboard bench for approx_add8_msb_pipe

module tb_approx_add8_msb_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] a_msb = '0;
  logic [5:0] b_msb = '0;
  logic [1:0] s_lsb = '0;
  logic       cin1 = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] sum;
  logic       cout;

  approx_add8_msb_pipe #(.MSB_W(6), .LSB_W(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_msb(a_msb), .b_msb(b_msb), .s_lsb(s_lsb), .cin1(cin1),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    int         acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_out = 0;
  int   n_sent = 0;
  int   stall_waits = 0;
  bit   check_lat = 1'b1;
  logic [7:0] last_sum = '0;
  logic       last_cout = 1'b0;
  bit   rand_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: plain integer arithmetic on the upper field.
  function automatic exp_t model(input int a, input int b, input int s, input int c, input int acc);
    exp_t e;
    int upper;
    upper = a + b + c;
    e.acc_cyc = acc;
    e.cout = (upper >= 64);
    e.sum = 8'(((upper % 64) * 4) + s);
`ifdef APPROX_ADD_SAT_EN
    if (upper >= 64) e.sum = 8'd255;
`endif
    return e;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the word has been taken.
  task automatic send(input logic [5:0] a, input logic [5:0] b, input logic [1:0] s, input logic c);
    int waits = 0;
    in_valid = 1'b1; a_msb = a; b_msb = b; s_lsb = s; cin1 = c;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(a, b, s, c, cyc));
        n_sent++;
        break;
      end
      waits++;
      stall_waits++;
      if (waits > 60) begin
        check("send_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_queue_empty", sb.size(), 0);
  endtask

  // Monitor: pops the scoreboard on each output transfer; checks stall stability.
  initial begin : monitor
    exp_t it;
    bit was_stall = 1'b0;
    logic [7:0] held_sum = '0;
    logic held_cout = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        was_stall = 1'b0;
      end else begin
        if (was_stall) begin
          check("stall_valid_held", int'(out_valid), 1);
          check("stall_sum_held", int'(sum), int'(held_sum));
          check("stall_cout_held", int'(cout), int'(held_cout));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_output", int'(sum), -1);
          end else begin
            it = sb.pop_front();
            check("sum", int'(sum), int'(it.sum));
            check("cout", int'(cout), int'(it.cout));
            if (check_lat) check("latency", cyc - it.acc_cyc, 2);
            last_sum = sum;
            last_cout = cout;
            n_out++;
          end
        end
        was_stall = out_valid && !out_ready;
        held_sum = sum;
        held_cout = cout;
      end
    end
  end

  initial begin : stim
    // Reset state
    #2;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_sum", int'(sum), 0);
    check("reset_cout", int'(cout), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    check("post_reset_in_ready", int'(in_ready), 1);
    check("post_reset_out_valid", int'(out_valid), 0);

    // Directed vectors
    send(6'h31, 6'h0E, 2'b11, 1'b0);
    drain();
    check("dir1_sum", int'(last_sum), 8'hFF);
    check("dir1_cout", int'(last_cout), 0);

    send(6'h3F, 6'h00, 2'b10, 1'b1);
    drain();
`ifdef APPROX_ADD_SAT_EN
    check("dir2_sum_sat", int'(last_sum), 8'hFF);
`else
    check("dir2_sum", int'(last_sum), 8'h02);
`endif
    check("dir2_cout", int'(last_cout), 1);

    send(6'h00, 6'h00, 2'b00, 1'b1);
    drain();
    check("dir3_sum", int'(last_sum), 8'h04);
    check("dir3_approx_error", 8'h06 - int'(last_sum), 2);
    check("dir3_cout", int'(last_cout), 0);

    // Back-to-back stream, out_ready high
    stall_waits = 0;
    for (int i = 0; i < 10; i++)
      send(6'($urandom), 6'($urandom), 2'($urandom), 1'($urandom));
    check("stream_in_ready_stays_high", stall_waits, 0);
    drain();

    // Stream with 5-cycle back-pressure
    check_lat = 1'b0;
    n_out = 0; n_sent = 0;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(6'($urandom), 6'($urandom), 2'($urandom), 1'($urandom));
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("stall_in_ready_low", int'(in_ready), 0);
        check("stall_out_valid", int'(out_valid), 1);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("stall_no_loss_dup", n_out, n_sent);

    // Randomized traffic with random back-pressure
    n_out = 0; n_sent = 0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          send(6'($urandom), 6'($urandom), 2'($urandom), 1'($urandom));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("random_no_loss_dup", n_out, n_sent);

    // Asynchronous reset with two words in flight
    check_lat = 1'b1;
    out_ready = 1'b0;
    send(6'h15, 6'h2A, 2'b01, 1'b1);
    send(6'h3F, 6'h3F, 2'b11, 1'b1);
    check("full_out_valid", int'(out_valid), 1);
    check("full_in_ready", int'(in_ready), 0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out_valid", int'(out_valid), 0);
    check("async_rst_sum", int'(sum), 0);
    check("async_rst_cout", int'(cout), 0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    check("after_rst_in_ready", int'(in_ready), 1);
    n_out = 0;
    repeat (10) @(posedge clk);
    #1;
    check("after_rst_no_output", n_out, 0);
    check("after_rst_out_valid", int'(out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/approx_add8_msb_pipe.md
Name: approx_add8_msb_pipe

Overview:
- Downstream stage of the 8-bit approximate adder.
- Consumes the 2-bit approximate LSB result (S = ~(A&B) per bit) and the carry CIN1 produced by the LSB block. Adds the upper operand bits exactly with CIN1 as carry-in.
- Assembles the full 8-bit approximate sum plus carry-out.
- Two-stage valid/ready pipeline so the adder can sit in a streaming datapath with back-pressure.

Parameters:
- MSB_W, 6, width of exact upper part (operand bits [7:2]).
- LSB_W, 2, width of approximate LSB field passed through.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream word valid
- in_ready  output  1  stage can accept a word this cycle
- a_msb  input  MSB_W  operand A upper bits
- b_msb  input  MSB_W  operand B upper bits
- s_lsb  input  LSB_W  approximate LSB sum from LSB stage
- cin1  input  1  carry from LSB stage into upper part
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sum  output  MSB_W+LSB_W  {upper exact sum, s_lsb}
- cout  output  1  carry-out of upper addition

Behaviour:
- One clock, clk. rst is asynchronous and active-high.
- Reset values: all valids clear; out_valid=0, sum=0, cout=0, in_ready=1 in the cycle after reset deasserts.
- Stage 1 (S1) registers a_msb, b_msb, s_lsb, cin1 and sets s1_valid.
- Stage 2 (S2):
  - Computes {c, u} = a_msb + b_msb + cin1, with MSB_W+1 bit unsigned arithmetic; no truncation before the carry is taken.
  - Registers sum = {u, s_lsb} and cout = c, and sets out_valid.
- Handshake rules:
  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
  - s2_adv = ~out_valid | out_ready.
  - s1_adv = s1_valid & s2_adv.
  - in_ready = ~s1_valid | s2_adv (combinational).
- Latency: a word accepted at edge N appears on out_valid at edge N+2 when there are no stalls.
- Throughput: 1 word/cycle with out_ready held high.
- Stall: while out_valid & ~out_ready, sum/cout/out_valid hold stable. S1 holds its word, and in_ready drops once S1 is occupied.
- Simultaneous accept and emit on a full pipe: S2 loads from S1 and S1 loads the new word in the same edge. No bubble, no loss, no duplicate.
- Empty pipe with out_ready low: S1 still advances into the empty S2.
- Input fields are sampled only on a transfer; values while in_valid=0 are don't-care.
- Reset mid-operation: in-flight words are discarded immediately and asynchronously, and outputs go to their reset values. No output is produced for a word accepted before reset.
- Sum wrap-around: u wraps modulo 2^MSB_W, and the overflow is reported on cout.
- No state machine beyond the two valid flags. Pipeline occupancy is 0, 1 or 2 words.

Optional Feature:
- Macro: APPROX_ADD_SAT_EN.
- Defined: when c=1, S2 registers sum as all ones (8'hFF at default widths) and cout=1. This is saturating addition.
- Not defined: sum wraps as described and cout carries the overflow.
- Timing and handshake are identical in both builds.

Test Plan:
- Reset, then a_msb=6'h31, b_msb=6'h0E, s_lsb=2'b11, cin1=0 (A=C5, B=3A) -> two edges later out_valid=1, sum=8'hFF, cout=0.
- a_msb=6'h3F, b_msb=6'h00, s_lsb=2'b10, cin1=1 (A=FF, B=01) -> sum=8'h02, cout=1. With APPROX_ADD_SAT_EN: sum=8'hFF, cout=1.
- a_msb=0, b_msb=0, s_lsb=2'b00, cin1=1 (A=03, B=03) -> sum=8'h04, cout=0. Check the known approximation error against the exact 8'h06.
- Stream of 10 back-to-back words with out_ready=1:
  - in_ready stays 1.
  - Results arrive in order, one per cycle, starting 2 cycles after the first accept.
- Hold out_ready=0 for 5 cycles during the stream:
  - in_ready drops after the pipe fills; sum/cout are stable.
  - After release, no word is lost or duplicated.
- Assert rst asynchronously between edges with 2 words in flight -> out_valid falls immediately, sum=0, cout=0; neither word is ever output.
